ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite memory slave that sits on the shared AHB interface directly downstream of the bus master VIP.
- Replaces the dummy slave as the real target for master-generated traffic.
- Word-organised internal SRAM array, programmable wait states, byte/halfword/word accesses, little-endian byte lanes.
- Two-cycle ERROR response for illegal accesses.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0.
- MEM_DEPTH, 256, number of 32-bit words; legal byte range is BASE_ADDR .. BASE_ADDR+4*MEM_DEPTH-1.
- WAIT_STATES, 1, data-phase wait cycles inserted per OKAY transfer; legal range 0..7.

Ports:
- clk  input  1  bus clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- hsel  input  1  slave select.
- haddr  input  32  transfer byte address (address phase).
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write, 0 = read.
- hsize  input  3  000 byte, 001 halfword, 010 word; other values are illegal.
- hwdata  input  32  write data (data phase).
- hready  input  1  bus-level ready; a transfer is accepted only when high.
- hreadyout  output  1  slave ready / data-phase completion.
- hresp  output  1  0 OKAY, 1 ERROR.
- hrdata  output  32  read data.

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset: state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, latched address/control cleared. Memory contents are not reset.
- Reset asserted mid-transfer aborts the transfer with no memory write.
- Accept condition, evaluated on each rising edge: hsel && hready && htrans[1]. On accept, latch haddr, hwrite, hsize.
- No accept (unselected, IDLE or BUSY) while in IDLE: stay in IDLE with zero-wait OKAY (hreadyout=1, hresp=0).
- Legality check is made at accept. Illegal if any of:
  - hsize > 2
  - halfword with haddr[0]=1
  - word with haddr[1:0]!=0
  - haddr outside the BASE_ADDR range
- States:
  - IDLE: hreadyout=1, hresp=0.
    - Legal accept with WAIT_STATES=0 -> DATA.
    - Legal accept with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
    - Illegal accept -> ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at counter==1 -> DATA.
  - DATA (completion cycle): hreadyout=1, hresp=0.
    - Write: hwdata byte lanes selected by latched size/addr[1:0] are written at the end of this cycle.
    - Read: hrdata = full 32-bit word at latched index, unused lanes not masked.
    - A new accept in this cycle is pipelined exactly as from IDLE; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1, no memory access -> ERR2.
  - ERR2: hreadyout=1, hresp=1. An accept in this cycle is handled as from IDLE; otherwise -> IDLE.
- Latency for an OKAY transfer: data phase lasts WAIT_STATES+1 cycles.
- Byte lanes (little-endian):
  - byte: lane = addr[1:0]
  - halfword: lanes {addr[1],0} and {addr[1],1}
  - word: all four lanes
- hrdata is 0 in every cycle other than a read DATA cycle.
- Word index = (haddr-BASE_ADDR)>>2.
- Write followed back-to-back by a read of the same word: the read returns the newly written data, because the write commits before the read's DATA cycle.
- Accepts are only sampled while hready=1. Address-phase signals seen while hreadyout=0 are ignored.

Test Plan:
- Reset, then idle bus -> hreadyout=1, hresp=0, hrdata=0 throughout.
- WAIT_STATES=1: word write 0xDEADBEEF @0x10, then read @0x10 -> write data phase 2 cycles (hreadyout 0,1); read completes with hrdata=0xDEADBEEF.
- Byte write 0xAA @0x11 over word 0x11223344 @0x10, then word read @0x10 -> 0x1122AA44. Halfword write 0x5566 @0x12, then word read -> 0x5566AA44.
- Back-to-back pipelined NONSEQ write 0x1 @0x20 then SEQ read @0x20 with WAIT_STATES=0 -> read DATA cycle returns 0x00000001, hreadyout never low.
- Word read @0x02 (misaligned), and read @BASE_ADDR+0x400 with MEM_DEPTH=256 -> each gives hresp=1 for 2 cycles with hreadyout 0 then 1; memory unchanged.
- rst pulsed during WAIT of a write of 0xCAFEF00D @0x30 -> outputs return to reset values immediately; later read @0x30 returns the prior contents, not 0xCAFEF00D.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised array, programmable wait states,
// little-endian byte/halfword/word lanes and a two-cycle ERROR response.
//   state  | meaning
//   IDLE   | no transfer in data phase, zero-wait OKAY
//   WAIT   | legal transfer stalled, counting down wait states
//   DATA   | completion cycle: write commits at end, read data driven
//   ERR1   | first ERROR cycle, bus held off
//   ERR2   | second ERROR cycle, next transfer may be accepted
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(4 * MEM_DEPTH);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [2:0]    size;
  logic          wr;
  logic          accept, legal, load;
  logic [32:0]   off;
  logic [3:0]    be;
  logic [31:0]   mem [MEM_DEPTH];
  logic          unused_ok;

  assign unused_ok = htrans[0];

  // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the limit check
  assign off    = {1'b0, haddr} - {1'b0, BASE_ADDR};
  assign accept = hsel && hready && htrans[1];
  assign legal  = (off < LIMIT) &&
                  ((hsize == 3'd0) ||
                   (hsize == 3'd1 && !haddr[0]) ||
                   (hsize == 3'd2 && haddr[1:0] == 2'b00));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          load = 1'b1;
          if (!legal) begin
            state_n = S_ERR1;
          end else if (WS == 3'd0) begin
            state_n = S_DATA;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 3'd1) state_n = S_DATA;
        else             cnt_n   = cnt - 3'd1;
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      idx   <= '0;
      lane  <= 2'b00;
      size  <= 3'd0;
      wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        idx  <= off[AW+1:2];
        lane <= haddr[1:0];
        size <= hsize;
        wr   <= hwrite;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (size)
      3'd0:    be = 4'b0001 << lane;
      3'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory contents survive reset; only the transfer state is cleared
  always_ff @(posedge clk) begin
    if (state == S_DATA && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign hrdata    = (state == S_DATA && !wr) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 and 0 wait states) on a shared bus,
// a transfer-level reference model checked every cycle, plus directed literal checks.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  hsel = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'h0;
  logic        stall = 1'b0;
  logic [1:0]  hreadyout, hresp, hready_bus;
  logic [31:0] hrdata [2];

  int errors = 0;
  int checks = 0;

  assign hready_bus = hreadyout & ~{2{stall}};

  always #5 clk = ~clk;

  ahb_sram_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

  ahb_sram_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

  // Reference model: each transfer is "busy" cycles of stall, then one completion cycle
  int          ws_of [2] = '{1, 0};
  int          busy  [2] = '{0, 0};
  bit          err   [2] = '{0, 0};
  bit          pend  [2] = '{0, 0};
  bit          pw    [2] = '{0, 0};
  logic [31:0] pa    [2] = '{32'h0, 32'h0};
  logic [2:0]  ps    [2] = '{3'd0, 3'd0};
  logic [31:0] mm    [2][256];

  function automatic bit legal_f(input logic [31:0] a, input logic [2:0] sz);
    return (a < 32'h400) && (sz <= 3'd2) && ((a % (32'd1 << sz)) == 32'd0);
  endfunction

  function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] sz);
    int n, first;
    logic [31:0] r;
    n     = 1 << sz;
    first = (int'(a % 4) / n) * n;
    r     = old;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + n) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        busy[k] <= 0;
        err[k]  <= 1'b0;
        pend[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (busy[k] > 0) begin
          busy[k] <= busy[k] - 1;
        end else begin
          if (pend[k] && !err[k] && pw[k])
            mm[k][pa[k][9:2]] <= merge_f(mm[k][pa[k][9:2]], hwdata, pa[k], ps[k]);
          if (hsel[k] && !stall && htrans[1]) begin
            pend[k] <= 1'b1;
            pw[k]   <= hwrite;
            pa[k]   <= haddr;
            ps[k]   <= hsize;
            if (legal_f(haddr, hsize)) begin
              err[k]  <= 1'b0;
              busy[k] <= ws_of[k];
            end else begin
              err[k]  <= 1'b1;
              busy[k] <= 1;
            end
          end else begin
            pend[k] <= 1'b0;
            err[k]  <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, k, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] erd;
      erd = (pend[k] && busy[k] == 0 && !err[k] && !pw[k]) ? mm[k][pa[k][9:2]] : 32'h0;
      chk("model_hreadyout", k, 32'(hreadyout[k]), 32'(busy[k] == 0));
      chk("model_hresp", k, 32'(hresp[k]), 32'(err[k]));
      chk("model_hrdata", k, hrdata[k], erd);
    end
  end

  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output bit resp, output int ncyc);
    int guard;
    @(posedge clk); #1;
    hsel    = 2'b00;
    hsel[k] = 1'b1;
    htrans  = 2'b10;
    hwrite  = wr;
    haddr   = a;
    hsize   = sz;
    guard   = 0;
    @(negedge clk);
    while (!hready_bus[k] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    hsel   = 2'b00;
    htrans = 2'b00;
    hwdata = wd;
    ncyc   = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!hreadyout[k] && ncyc < 20);
    rd   = hrdata[k];
    resp = hresp[k];
    if (ncyc >= 20 || guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout dut%0d addr=%h guard=%0d cycles=%0d", k, a, guard, ncyc);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          resp;
    int          nc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_hreadyout", 0, 32'(hreadyout[0]), 32'd1);
    chk("reset_hresp", 0, 32'(hresp[0]), 32'd0);
    chk("reset_hrdata", 1, hrdata[1], 32'h0);

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 256; w++)
        xfer(k, 1'b1, 32'(w * 4), 3'd2, $urandom, rd, resp, nc);

    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, resp, nc);
    chk("wr_data_phase_cycles", 0, 32'(nc), 32'd2);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, nc);
    chk("rd_deadbeef", 0, rd, 32'hDEADBEEF);
    chk("rd_data_phase_cycles", 0, 32'(nc), 32'd2);

    xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, resp, nc);
    xfer(0, 1'b1, 32'h11, 3'd0, 32'hFFFFAAFF, rd, resp, nc);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, nc);
    chk("byte_lane1", 0, rd, 32'h1122AA44);
    xfer(0, 1'b1, 32'h12, 3'd1, 32'h5566FFFF, rd, resp, nc);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, nc);
    chk("half_upper", 0, rd, 32'h5566AA44);

    @(posedge clk); #1;
    hsel = 2'b10; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b11; hwrite = 1'b0; hwdata = 32'h1;
    @(negedge clk);
    chk("pipe_wr_ready", 1, 32'(hreadyout[1]), 32'd1);
    @(posedge clk); #1;
    hsel = 2'b00; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("pipe_rd_data", 1, hrdata[1], 32'h1);
    chk("pipe_rd_ready", 1, 32'(hreadyout[1]), 32'd1);

    xfer(0, 1'b0, 32'h02, 3'd2, 32'h0, rd, resp, nc);
    chk("misaligned_resp", 0, 32'(resp), 32'd1);
    chk("misaligned_cycles", 0, 32'(nc), 32'd2);
    xfer(0, 1'b0, 32'h400, 3'd2, 32'h0, rd, resp, nc);
    chk("range_resp", 0, 32'(resp), 32'd1);
    chk("range_rdata", 0, rd, 32'h0);
    xfer(0, 1'b1, 32'h12, 3'd2, 32'hFFFFFFFF, rd, resp, nc);
    chk("misaligned_wr_resp", 0, 32'(resp), 32'd1);
    xfer(0, 1'b1, 32'h10, 3'd3, 32'hFFFFFFFF, rd, resp, nc);
    chk("bad_size_resp", 0, 32'(resp), 32'd1);

    @(posedge clk); #1;
    stall = 1'b1; hsel = 2'b01; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    @(posedge clk); #1;
    stall = 1'b0; hsel = 2'b00; htrans = 2'b00; hwdata = 32'h0;
    @(negedge clk);
    chk("hready_low_no_accept", 0, 32'(hreadyout[0]), 32'd1);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, nc);
    chk("mem_unchanged", 0, rd, 32'h5566AA44);

    xfer(0, 1'b1, 32'h30, 3'd2, 32'h12345678, rd, resp, nc);
    @(posedge clk); #1;
    hsel = 2'b01; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 2'b00; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("wait_before_reset", 0, 32'(hreadyout[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_hreadyout", 0, 32'(hreadyout[0]), 32'd1);
    chk("rst_hresp", 0, 32'(hresp[0]), 32'd0);
    chk("rst_hrdata", 0, hrdata[0], 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    xfer(0, 1'b0, 32'h30, 3'd2, 32'h0, rd, resp, nc);
    chk("rst_aborted_write", 0, rd, 32'h12345678);

    repeat (3000) begin
      @(posedge clk); #1;
      hsel   = 2'($urandom);
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      stall  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0)     haddr = 32'h400 + ($urandom & 32'hFF);
      else if ($urandom_range(0, 1) == 0) haddr = $urandom_range(0, 32'h3F);
      else                                haddr = $urandom_range(0, 32'h3FF);
      if ($urandom_range(0, 7) == 0) hsize = 3'($urandom_range(3, 7));
      else                           hsize = 3'($urandom_range(0, 2));
      hwdata = $urandom;
    end
    @(posedge clk); #1;
    hsel = 2'b00; htrans = 2'b00; stall = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
